// File: rtl/square_draw_queue.sv
// Request FIFO and one-at-a-time sequencer feeding the 4x4 square drawer.
// Each queued request is held on sq_* while the drawer's plot rises and falls.
module square_draw_queue #(
  parameter int DEPTH          = 4,
  parameter int LAUNCH_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_x,
  input  logic [6:0]               req_y,
  input  logic [2:0]               req_colour,
  input  logic                     req_draw,
  input  logic                     sq_plot,
  output logic                     sq_go,
  output logic [7:0]               sq_x,
  output logic [6:0]               sq_y,
  output logic [2:0]               sq_colour,
  output logic                     sq_draw,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     stall_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 19;
  localparam int TMO_W = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAW   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             push, pop, timeout;

  // Ready is based on the pre-pop count, so a full FIFO stays closed even
  // in the cycle it launches.
  assign req_ready = (count < CNT_FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign timeout   = (state == LAUNCH) && !sq_plot && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {req_x, req_y, req_colour, req_draw};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Active request is captured only on IDLE->LAUNCH and held until the next launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq_x      <= '0;
      sq_y      <= '0;
      sq_colour <= '0;
      sq_draw   <= 1'b0;
    end else if (pop) begin
      {sq_x, sq_y, sq_colour, sq_draw} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (pop) begin
      tmo_cnt <= '0;
    end else if ((state == LAUNCH) && !sq_plot) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      if (req_valid && !req_ready) overflow  <= 1'b1;
      if (timeout)                 stall_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LAUNCH;
      LAUNCH: begin
        if (sq_plot)      state_nxt = DRAW;
        else if (timeout) state_nxt = IDLE;
      end
      DRAW:    if (!sq_plot) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sq_go = (state == LAUNCH);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_square_draw_queue.sv
// Bench for square_draw_queue: a transaction-level model (request queue plus
// active-request phase) predicts every output after each clock edge.
module tb_square_draw_queue;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic       req_draw;
  logic       sq_plot;
  logic       sq_go;
  logic [7:0] sq_x;
  logic [6:0] sq_y;
  logic [2:0] sq_colour;
  logic       sq_draw;
  logic       busy;
  logic [2:0] count;
  logic       overflow, stall_err;

  always #5 clk = ~clk;

  square_draw_queue #(.DEPTH(DEPTH), .LAUNCH_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_draw(req_draw),
    .sq_plot(sq_plot), .sq_go(sq_go),
    .sq_x(sq_x), .sq_y(sq_y), .sq_colour(sq_colour), .sq_draw(sq_draw),
    .busy(busy), .count(count), .overflow(overflow), .stall_err(stall_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending requests, the active one, and its phase.
  logic [18:0] m_q[$];
  logic [18:0] m_cur;
  bit          m_active, m_seen, m_ovf, m_stall;
  int          m_wait;

  // Drawer model: mode 0 normal, 1 plot stuck high, 2 plot stuck low.
  int mode = 0;
  int dr_cnt = -1;
  int dr_lat = 2;
  int lat_min = 2, lat_max = 2;
  int go_run = 0, last_run = 0;

  function automatic logic plot_val();
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'b0;
    return (dr_cnt >= dr_lat) && (dr_cnt < dr_lat + 16);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur = '0; m_active = 0; m_seen = 0; m_ovf = 0; m_stall = 0; m_wait = 0;
    dr_cnt = -1; go_run = 0;
  endtask

  task automatic model_edge(input bit pv, input logic [18:0] d, input bit pl);
    bit acc;
    acc = pv && (m_q.size() < DEPTH);
    if (pv && !acc) m_ovf = 1;
    if (!m_active) begin
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_active = 1; m_seen = 0; m_wait = 0;
      end
    end else if (!m_seen) begin
      if (pl) m_seen = 1;
      else if (m_wait == TMO - 1) begin m_stall = 1; m_active = 0; end
      else m_wait++;
    end else if (!pl) begin
      m_active = 0;
    end
    if (acc) m_q.push_back(d);
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_go"},     sq_go,     m_active && !m_seen);
    chk({ph, "_busy"},   busy,      m_active);
    chk({ph, "_count"},  count,     m_q.size());
    chk({ph, "_x"},      sq_x,      m_cur[18:11]);
    chk({ph, "_y"},      sq_y,      m_cur[10:4]);
    chk({ph, "_colour"}, sq_colour, m_cur[3:1]);
    chk({ph, "_draw"},   sq_draw,   m_cur[0]);
    chk({ph, "_ovf"},    overflow,  m_ovf);
    chk({ph, "_stall"},  stall_err, m_stall);
  endtask

  task automatic step(input bit pv, input logic [18:0] d);
    logic pl;
    @(negedge clk);
    req_valid = pv;
    {req_x, req_y, req_colour, req_draw} = d;
    pl = plot_val();
    sq_plot = pl;
    chk("ready", req_ready, m_q.size() < DEPTH);
    @(posedge clk);
    model_edge(pv, d, pl);
    #1;
    check_outputs("cyc");
    if (sq_go) go_run++;
    else if (go_run > 0) begin last_run = go_run; go_run = 0; end
    if (dr_cnt >= 0) begin
      dr_cnt++;
      if (dr_cnt >= dr_lat + 16) dr_cnt = -1;
    end else if (sq_go) begin
      dr_cnt = 0;
      dr_lat = $urandom_range(lat_max, lat_min);
    end
  endtask

  task automatic set_mode(input int m);
    mode = m;
    dr_cnt = -1;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (m_q.size() == 0 && !m_active) break;
      step(1'b0, '0);
    end
    chk("drain", m_q.size() + int'(m_active), 0);
  endtask

  task automatic do_reset(input string ph);
    @(negedge clk);
    #2;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    model_reset();
    check_outputs(ph);
    repeat (2) @(negedge clk);
    sq_plot = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    {req_x, req_y, req_colour, req_draw} = '0;
    sq_plot = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("rst0");
    reset = 1'b0;

    // Single request with a 2-cycle drawer start latency
    step(1'b1, {8'd10, 7'd20, 3'b100, 1'b1});
    chk("single_go_early", sq_go, 0);
    step(1'b0, '0);
    chk("single_go", sq_go, 1);
    chk("single_x", sq_x, 10);
    chk("single_y", sq_y, 20);
    chk("single_cnt", count, 0);
    drain();

    // Fill with drawer stuck in plot, then release
    set_mode(1);
    for (int i = 0; i < 6; i++) step(1'b1, 19'($urandom));
    step(1'b0, '0);
    chk("fill_cnt", count, 4);
    chk("fill_ready", req_ready, 0);
    chk("fill_ovf", overflow, 1);
    set_mode(0);
    drain();

    // Erase request
    step(1'b1, {8'd5, 7'd6, 3'b111, 1'b0});
    step(1'b0, '0);
    chk("erase_draw", sq_draw, 0);
    chk("erase_colour", sq_colour, 3'b111);
    drain();

    // Push in the same cycle as an IDLE->LAUNCH pop with two queued
    set_mode(1);
    for (int i = 0; i < 3; i++) step(1'b1, 19'($urandom));
    set_mode(0);
    for (int i = 0; i < 50; i++) begin
      if (!m_active) break;
      step(1'b0, '0);
    end
    chk("pushpop_pre", m_q.size(), 2);
    step(1'b1, 19'($urandom));
    chk("pushpop_cnt", count, 2);
    drain();

    // Randomized traffic: sparse then dense, random drawer latency
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) step($urandom_range(3, 0) == 0, 19'($urandom));
    for (int i = 0; i < 300; i++) step($urandom_range(3, 0) != 0, 19'($urandom));
    drain();

    // Launch timeout with plot stuck low
    set_mode(2);
    go_run = 0; last_run = 0;
    step(1'b1, 19'($urandom));
    step(1'b1, 19'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    chk("tmo_len", last_run, TMO);
    chk("tmo_stall", stall_err, 1);
    chk("tmo_next_go", sq_go, 1);
    set_mode(0);
    drain();

    // Reset during DRAW with three requests queued
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) step(1'b1, 19'($urandom));
    for (int i = 0; i < 20; i++) begin
      if (m_seen && m_active) break;
      step(1'b0, '0);
    end
    chk("mid_in_draw", m_active && m_seen, 1);
    chk("mid_queued", m_q.size(), 3);
    do_reset("mid_rst");
    for (int i = 0; i < 20; i++) step(1'b0, '0);
    chk("post_rst_go", sq_go, 0);
    chk("post_rst_cnt", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
